// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the register-file slave FSM states
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LAST, ST_ERR1, ST_ERR2} state_t;
endpackage

// File: rtl/ahb_wait_counter.sv
// ahb_wait_counter: loadable 4-bit down-counter with zero flag (i_load wins over i_dec, stops at 0)
module ahb_wait_counter (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [3:0] i_val,
  input  logic       i_dec,
  output logic       o_zero
);
  logic [3:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec && !o_zero) r_cnt <= r_cnt - 4'd1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/ahb_regfile_slave.sv
// ahb_regfile_slave: AHB-Lite slave with NUM_REGS x 32-bit registers, WAIT_STATES wait cycles, two-cycle ERROR
// Ports: HCLK/HRESETn clock and async active-low reset; HSEL/HADDR/HTRANS/HWRITE/HSIZE/HREADY address phase;
// HWDATA write data phase; HRDATA/HREADYOUT/HRESP slave response.
module ahb_regfile_slave
  import ahb_pkg::*;
#(
  parameter int          NUM_REGS    = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [3:0] WS_LOAD = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
  state_t r_state, w_next, w_pipe;
  logic r_write;
  logic [IW-1:0] r_idx;
  logic [31:0] r_regs [NUM_REGS];
  logic w_take, w_err, w_zero, w_load;
  logic [31:0] w_off;
  // A new address phase can only be taken in cycles where this slave is ready.
  assign w_take = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ) &&
                  (r_state == ST_IDLE || r_state == ST_LAST || r_state == ST_ERR2);
  assign w_off = HADDR - BASE_ADDR;
  assign w_err = HADDR[1:0] != 2'b00 || HSIZE != HSIZE_WORD || w_off >= SPAN;
  always_comb begin
    w_pipe = !w_take ? ST_IDLE : w_err ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_LAST;
    w_next = r_state == ST_WAIT ? (w_zero ? ST_LAST : ST_WAIT) :
             r_state == ST_ERR1 ? ST_ERR2 : w_pipe;
  end
  assign w_load = w_next == ST_WAIT && r_state != ST_WAIT;
  ahb_wait_counter u_cnt (
    .i_clk  (HCLK),
    .i_rst_n(HRESETn),
    .i_load (w_load),
    .i_val  (WS_LOAD),
    .i_dec  (r_state == ST_WAIT),
    .o_zero (w_zero)
  );
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_write <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_write <= HWRITE;
        r_idx   <= HADDR[IW+1:2];
      end
    end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    else if (r_state == ST_LAST && r_write) r_regs[r_idx] <= HWDATA;
  assign HREADYOUT = !(r_state == ST_WAIT || r_state == ST_ERR1);
  assign HRESP     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (r_state == ST_LAST && !r_write) ? r_regs[r_idx] : 32'h0;
endmodule
